// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 SEQ stage sequencer: instruction codes,
// architectural status codes, sequencer states and the per-icode class
// flags produced by y86_icode_class.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT
  } state_e;

  typedef struct packed {
    logic needs_mem;  // instruction has a MEMORY stage
    logic mem_is_wr;  // MEMORY stage writes (else reads)
    logic writes_e;   // writes the register file via dstE
    logic writes_m;   // writes the register file via dstM
    logic sets_cc;    // updates the condition codes
    logic valid;      // icode is a defined instruction
  } icode_class_t;

endpackage

// File: rtl/y86_icode_class.sv
// Combinational instruction classifier.
// Ports:
//   icode_i  latched instruction code
//   flags_o  class flags (needs_mem, mem_is_wr, writes_e, writes_m, sets_cc, valid)
module y86_icode_class
  import y86_pkg::*;
(
  input  logic [3:0]   icode_i,
  output icode_class_t flags_o
);

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    flags_o = '0;
    case (icode_i)
      IHALT, INOP, IJXX: begin
        flags_o.valid = 1'b1;
      end
      IRRMOVQ, IIRMOVQ: begin
        flags_o.valid    = 1'b1;
        flags_o.writes_e = 1'b1;
      end
      IRMMOVQ: begin
        flags_o.valid     = 1'b1;
        flags_o.needs_mem = 1'b1;
        flags_o.mem_is_wr = 1'b1;
      end
      IMRMOVQ: begin
        flags_o.valid     = 1'b1;
        flags_o.needs_mem = 1'b1;
        flags_o.writes_m  = 1'b1;
      end
      IOPQ: begin
        flags_o.valid    = 1'b1;
        flags_o.writes_e = 1'b1;
        flags_o.sets_cc  = 1'b1;
      end
      ICALL, IPUSHQ: begin
        flags_o.valid     = 1'b1;
        flags_o.needs_mem = 1'b1;
        flags_o.mem_is_wr = 1'b1;
        flags_o.writes_e  = 1'b1;
      end
      IRET: begin
        flags_o.valid     = 1'b1;
        flags_o.needs_mem = 1'b1;
        flags_o.writes_e  = 1'b1;
      end
      IPOPQ: begin
        flags_o.valid     = 1'b1;
        flags_o.needs_mem = 1'b1;
        flags_o.writes_e  = 1'b1;
        flags_o.writes_m  = 1'b1;
      end
      default: flags_o = '0;
    endcase
  end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle stage sequencer for the Y86 SEQ datapath.
// Steps one instruction through FETCH, DECODE, EXECUTE, [MEMORY], WRITEBACK
// and PCUPD, drives the per-stage enables, owns the status register and
// the cycle / retired-instruction counters. All outputs are decoded from
// registered state only.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 leaves IDLE
//   icode, imem_error     fetch results (sampled in FETCH)
//   cnd                   execute condition (sampled in EXECUTE)
//   mem_ack, dmem_error   data memory handshake (sampled in MEMORY)
//   fetch_en .. pc_we     stage enables
//   stat, halted          architectural status
//   cycle_cnt, instr_cnt  saturating performance counters
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             cnd,
  input  logic             mem_ack,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             cc_we,
  output logic             mem_req,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_we_e,
  output logic             reg_we_m,
  output logic             pc_we,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  stat_e             stat_q, stat_d;
  logic [3:0]        icode_q, icode_d;
  logic              cnd_q, cnd_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cycle_q, instr_q;
  icode_class_t      cls;

  y86_icode_class u_class (
    .icode_i (icode_q),
    .flags_o (cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      icode_q <= '0;
      cnd_q   <= 1'b0;
      wait_q  <= '0;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      wait_q  <= wait_d;
      if (state_q != S_IDLE && state_q != S_HALT && cycle_q != CNT_MAX)
        cycle_q <= cycle_q + 1'b1;
      if (state_q == S_PCUPD && instr_q != CNT_MAX)
        instr_q <= instr_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    stat_d   = stat_q;
    icode_d  = icode_q;
    cnd_d    = cnd_q;
    wait_d   = wait_q;
    fetch_en = 1'b0;
    cc_we    = 1'b0;
    mem_req  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    reg_we_e = 1'b0;
    reg_we_m = 1'b0;
    pc_we    = 1'b0;
    halted   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        fetch_en = 1'b1;
        icode_d  = icode;
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (icode > IPOPQ) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == IHALT) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        cc_we   = cls.sets_cc;
        cnd_d   = cnd;
        wait_d  = '0;
        state_d = cls.needs_mem ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        mem_req = 1'b1;
        mem_wr  = cls.mem_is_wr;
        mem_rd  = ~cls.mem_is_wr;
        // Ack is checked before the timeout so an ack on the last allowed cycle succeeds.
        if (mem_ack) begin
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_HALT;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITEBACK: begin
        // rrmovq doubles as cmovXX: its dstE write depends on the latched condition.
        reg_we_e = cls.valid & cls.writes_e & ((icode_q != IRRMOVQ) | cnd_q);
        reg_we_m = cls.valid & cls.writes_m;
        state_d  = S_PCUPD;
      end
      S_PCUPD: begin
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign stat      = stat_q;
  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Scoreboard bench for y86_seq_ctrl. The driver plans each instruction,
// computes its expected per-instruction footprint from the instruction-set
// rules and pushes it to a queue; an independent monitor measures each
// instruction window (fetch to pc_we or halt) and compares on completion.
module tb_y86_seq_ctrl;
  import y86_pkg::*;

  localparam int CNT_W       = 32;
  localparam int MEM_TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       icode = '0;
  logic             imem_error = 1'b0;
  logic             cnd = 1'b0;
  logic             mem_ack = 1'b0;
  logic             dmem_error = 1'b0;
  logic             fetch_en, cc_we, mem_req, mem_rd, mem_wr;
  logic             reg_we_e, reg_we_m, pc_we, halted;
  logic [2:0]       stat;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  y86_seq_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode),
    .imem_error(imem_error), .cnd(cnd), .mem_ack(mem_ack),
    .dmem_error(dmem_error), .fetch_en(fetch_en), .cc_we(cc_we),
    .mem_req(mem_req), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_we_e(reg_we_e), .reg_we_m(reg_we_m), .pc_we(pc_we),
    .stat(stat), .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // ack_wait < 0 means the memory never acknowledges.
  typedef struct {
    int icode;
    bit imem_err;
    bit cnd;
    int ack_wait;
    bit dmem_err;
  } instr_t;

  typedef struct {
    int retire;
    int stat;
    int cycles;
    int cc;
    int we_e;
    int we_m;
    int req;
    int rd;
    int wr;
    int pc;
    int cc_at;
    int we_at;
    int cyc_exp;
    int ins_exp;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  int   tot_cycles, retired, last_stat;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference footprint of one instruction derived from the ISA rules.
  function automatic exp_t model(input instr_t ins, input int cyc_before, input int ret_before);
    exp_t e;
    bit   is_mem;
    e = '{default: 0};
    is_mem = ins.icode inside {4, 5, 8, 9, 10, 11};
    if (ins.imem_err) begin
      e.stat = 3; e.cycles = 1;
    end else if (ins.icode > 11) begin
      e.stat = 4; e.cycles = 1;
    end else if (ins.icode == 0) begin
      e.stat = 2; e.cycles = 1;
    end else if (is_mem) begin
      e.req = (ins.ack_wait < 0) ? MEM_TIMEOUT : ins.ack_wait + 1;
      if (ins.icode inside {5, 9, 11}) e.rd = e.req;
      else e.wr = e.req;
      if (ins.ack_wait < 0 || ins.dmem_err) begin
        e.stat = 3; e.cycles = 3 + e.req;
      end else begin
        e.retire = 1; e.stat = 1; e.cycles = 5 + e.req; e.pc = 1;
        e.we_e = (ins.icode inside {8, 9, 10, 11}) ? 1 : 0;
        e.we_m = (ins.icode inside {5, 11}) ? 1 : 0;
      end
    end else begin
      e.retire = 1; e.stat = 1; e.cycles = 5; e.pc = 1;
      e.cc   = (ins.icode == 6) ? 1 : 0;
      e.we_e = (ins.icode inside {3, 6} || (ins.icode == 2 && ins.cnd)) ? 1 : 0;
    end
    e.cc_at   = e.cc ? 3 : 0;
    e.we_at   = (e.we_e + e.we_m > 0) ? e.cycles - 1 : 0;
    e.cyc_exp = e.retire ? cyc_before + e.cycles - 1 : cyc_before + e.cycles;
    e.ins_exp = ret_before;
    return e;
  endfunction

  function automatic instr_t mk(input int ic, input bit c, input int aw, input bit de, input bit ie);
    instr_t i;
    i.icode = ic; i.cnd = c; i.ack_wait = aw; i.dmem_err = de; i.imem_err = ie;
    return i;
  endfunction

  // ---------------- monitor ----------------
  int m_act = 0;
  int m_cyc, m_cc, m_e, m_m, m_req, m_rd, m_wr, m_pc, m_cc_at, m_we_at;

  task automatic mon_compare(input int ended_retire);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_underflow: got completion expected none (t=%0t)", $time);
      return;
    end
    e = sb_q.pop_front();
    check("end_retire", ended_retire, e.retire);
    check("stat", int'(stat), e.stat);
    check("window_cycles", m_cyc, e.cycles);
    check("cc_we_cycles", m_cc, e.cc);
    check("reg_we_e_cycles", m_e, e.we_e);
    check("reg_we_m_cycles", m_m, e.we_m);
    check("mem_req_cycles", m_req, e.req);
    check("mem_rd_cycles", m_rd, e.rd);
    check("mem_wr_cycles", m_wr, e.wr);
    check("pc_we_cycles", m_pc, e.pc);
    check("cc_we_pos", m_cc_at, e.cc_at);
    check("reg_we_pos", m_we_at, e.we_at);
    check("cycle_cnt", int'(cycle_cnt), e.cyc_exp);
    check("instr_cnt", int'(instr_cnt), e.ins_exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_act = 0;
    end else begin
      if (mem_req | mem_rd | mem_wr)
        check("mem_qualifier", int'({mem_req, mem_rd ^ mem_wr}), 3);
      if (halted && m_act != 0) begin
        mon_compare(0);
        m_act = 0;
      end else begin
        if (fetch_en) begin
          if (m_act != 0) begin
            n_cmp++; n_err++;
            $display("FAIL window_overrun: got fetch_en expected pc_we first (t=%0t)", $time);
          end
          m_act = 1;
          m_cyc = 0; m_cc = 0; m_e = 0; m_m = 0; m_req = 0;
          m_rd = 0; m_wr = 0; m_pc = 0; m_cc_at = 0; m_we_at = 0;
        end
        if (m_act != 0) begin
          m_cyc++;
          m_cc  += int'(cc_we);
          m_e   += int'(reg_we_e);
          m_m   += int'(reg_we_m);
          m_req += int'(mem_req);
          m_rd  += int'(mem_rd);
          m_wr  += int'(mem_wr);
          m_pc  += int'(pc_we);
          if (cc_we) m_cc_at = m_cyc;
          if (reg_we_e | reg_we_m) m_we_at = m_cyc;
          if (pc_we) begin
            mon_compare(1);
            m_act = 0;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  function automatic int outs_packed();
    return int'({fetch_en, cc_we, mem_req, mem_rd, mem_wr, reg_we_e, reg_we_m, pc_we, halted});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; icode = '0; imem_error = 1'b0; cnd = 1'b0;
    mem_ack = 1'b0; dmem_error = 1'b0;
    sb_q.delete();
    tot_cycles = 0; retired = 0; last_stat = 1;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs_packed(), 0);
    check("reset_stat", int'(stat), 1);
    check("reset_cycle_cnt", int'(cycle_cnt), 0);
    check("reset_instr_cnt", int'(instr_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at the negedge where fetch_en is visible; returns at the negedge
  // where the next fetch or the halt is visible.
  task automatic issue(input instr_t ins, output bit stop);
    exp_t e;
    int   req_cnt;
    req_cnt = 0;
    check("cycle_cnt_at_fetch", int'(cycle_cnt), tot_cycles);
    check("instr_cnt_at_fetch", int'(instr_cnt), retired);
    e = model(ins, tot_cycles, retired);
    sb_q.push_back(e);
    tot_cycles += e.cycles;
    retired    += e.retire;
    last_stat   = e.stat;
    icode = 4'(ins.icode); imem_error = ins.imem_err; cnd = ins.cnd;
    mem_ack = 1'b0; dmem_error = 1'b0;
    stop = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (fetch_en) begin stop = 1'b0; return; end
      if (halted) begin mem_ack = 1'b0; dmem_error = 1'b0; return; end
      if (mem_req) begin
        req_cnt++;
        mem_ack    = (ins.ack_wait >= 0) && (req_cnt == ins.ack_wait + 1);
        dmem_error = mem_ack && ins.dmem_err;
      end else begin
        mem_ack = 1'b0; dmem_error = 1'b0;
      end
    end
    n_cmp++; n_err++;
    $display("FAIL issue_bound: got no fetch/halt expected one within 64 cycles (t=%0t)", $time);
  endtask

  task automatic run_prog(input instr_t prog[$]);
    bit stop;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fetch_after_start", int'(fetch_en), 1);
    if (!fetch_en) return;
    stop = 1'b0;
    foreach (prog[k]) begin
      issue(prog[k], stop);
      if (stop) break;
    end
    check("ended_halted", int'(halted), 1);
    // HALT is sticky: start must not restart the sequencer.
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("halt_sticky", int'(halted), 1);
    check("halt_stat_frozen", int'(stat), last_stat);
    check("halt_no_fetch", int'(fetch_en), 0);
    check("halt_cycle_frozen", int'(cycle_cnt), tot_cycles);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic reset_mid_memory();
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    icode = IMRMOVQ; cnd = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    check("reached_memory", int'(mem_req), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", outs_packed(), 0);
    check("rst_async_stat", int'(stat), 1);
    check("rst_async_cycle_cnt", int'(cycle_cnt), 0);
    check("rst_async_instr_cnt", int'(instr_cnt), 0);
    @(negedge clk);
    rst = 1'b0; icode = '0;
    repeat (3) @(negedge clk);
    check("idle_after_rst", outs_packed(), 0);
    check("idle_cycle_cnt", int'(cycle_cnt), 0);
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i.icode    = ($urandom_range(0, 99) < 4) ? int'($urandom_range(12, 15)) : int'($urandom_range(1, 11));
    i.imem_err = ($urandom_range(0, 49) == 0);
    i.cnd      = 1'($urandom_range(0, 1));
    i.ack_wait = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 5));
    i.dmem_err = ($urandom_range(0, 24) == 0);
    return i;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t p[$];
    @(negedge clk);

    p = '{mk(1, 0, 0, 0, 0), mk(0, 0, 0, 0, 0)};                 run_prog(p);
    p = '{mk(6, 1, 0, 0, 0), mk(0, 0, 0, 0, 0)};                 run_prog(p);
    p = '{mk(5, 0, 3, 0, 0), mk(0, 0, 0, 0, 0)};                 run_prog(p);
    p = '{mk(4, 1, 1, 1, 0), mk(1, 0, 0, 0, 0)};                 run_prog(p);
    p = '{mk(2, 0, 0, 0, 0), mk(2, 1, 0, 0, 0), mk(13, 0, 0, 0, 0)}; run_prog(p);
    p = '{mk(5, 0, -1, 0, 0), mk(1, 0, 0, 0, 0)};                run_prog(p);
    p = '{mk(11, 0, MEM_TIMEOUT - 1, 0, 0), mk(0, 0, 0, 0, 0)};  run_prog(p);
    p = '{mk(0, 0, 0, 0, 0)};                                    run_prog(p);
    p = '{mk(1, 0, 0, 0, 1), mk(1, 0, 0, 0, 0)};                 run_prog(p);
    p = '{mk(8, 0, 0, 0, 0), mk(9, 0, 2, 0, 0), mk(10, 0, 1, 0, 0),
          mk(7, 1, 0, 0, 0), mk(3, 0, 0, 0, 0), mk(0, 0, 0, 0, 0)}; run_prog(p);

    reset_mid_memory();

    for (int r = 0; r < 12; r++) begin
      int len;
      p.delete();
      len = int'($urandom_range(1, 10));
      for (int k = 0; k < len; k++) p.push_back(rand_instr());
      p.push_back(mk(0, 0, 0, 0, 0));
      run_prog(p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
